// File: rtl/result_collector.sv
// Collects the 2x2 result matrix from each of the three compute engines, then plays
// the 12 captured values out one after another, each for HOLD_CYCLES clocks.
module result_collector #(
  parameter int DW          = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic          pe_c00,
  input  logic          pe_c01,
  input  logic          pe_c10,
  input  logic          pe_c11,
  input  logic          sa2x2_c00,
  input  logic          sa2x2_c01,
  input  logic          sa2x2_c10,
  input  logic          sa2x2_c11,
  input  logic          sa3x3_c00,
  input  logic          sa3x3_c01,
  input  logic          sa3x3_c10,
  input  logic          sa3x3_c11,
  input  logic [DW-1:0] pe_out,
  input  logic [DW-1:0] sa2x2_out,
  input  logic [DW-1:0] sa3x3_out,
  output logic [DW-1:0] display_output,
  output logic [3:0]    display_idx,
  output logic          display_valid,
  output logic          busy,
  output logic          all_captured
);

  localparam int DWELL_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HOLD_CYCLES - 1);
  localparam logic [3:0] LAST_SLOT = 4'd11;

  typedef enum logic [1:0] {COLLECT, SHOW, FINISHED} state_t;

  state_t               state, state_nxt;
  logic [3:0]           idx, idx_nxt;
  logic [DWELL_W-1:0]   dwell, dwell_nxt;
  logic [DW-1:0]        r [12];
  logic [11:0]          cap;
  logic [11:0]          stb;
  logic [DW-1:0]        src [3];

  // Slot index is engine*4 + cell, so strobe bit i pairs with engine i/4.
  assign stb = {sa3x3_c11, sa3x3_c10, sa3x3_c01, sa3x3_c00,
                sa2x2_c11, sa2x2_c10, sa2x2_c01, sa2x2_c00,
                pe_c11,    pe_c10,    pe_c01,    pe_c00};
  assign src[0] = pe_out;
  assign src[1] = sa2x2_out;
  assign src[2] = sa3x3_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 12; i++) r[i] <= '0;
      cap <= '0;
    end else if (state == COLLECT) begin
      for (int i = 0; i < 12; i++) begin
        if (stb[i]) begin
          r[i]   <= src[i/4];
          cap[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
      idx   <= '0;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      dwell <= dwell_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dwell_nxt = dwell;
    case (state)
      COLLECT: begin
        if (done) begin
          state_nxt = SHOW;
          idx_nxt   = '0;
          dwell_nxt = '0;
        end
      end
      SHOW: begin
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (idx == LAST_SLOT) state_nxt = FINISHED;
          else                  idx_nxt   = idx + 4'd1;
        end else begin
          dwell_nxt = dwell + DWELL_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs depend only on registered state, never directly on inputs.
  always_comb begin
    display_output = '0;
    display_idx    = '0;
    display_valid  = 1'b0;
    case (state)
      SHOW: begin
        display_output = r[idx];
        display_idx    = idx;
        display_valid  = 1'b1;
      end
      FINISHED: begin
        display_output = r[11];
        display_idx    = LAST_SLOT;
      end
      default: ;
    endcase
  end

  assign busy         = display_valid;
  assign all_captured = &cap;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: two builds (HOLD_CYCLES 4 and 1) share stimulus and are
// checked each cycle against a slot-array / elapsed-time model, plus literal spot values.
module tb_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done = 1'b0;
  logic [11:0] stb = '0;
  logic [7:0]  dat [3];

  logic [7:0]  d_out   [2];
  logic [3:0]  d_idx   [2];
  logic        d_valid [2];
  logic        d_busy  [2];
  logic        d_allc  [2];

  int checks = 0;
  int errors = 0;

  // Model: slot contents, capture mask, and per-build phase plus cycles elapsed in SHOW.
  logic [7:0]  m_r [12];
  logic [11:0] m_cap = '0;
  int          m_phase [2];
  int          m_t [2];
  int          hold [2];

  always #5 clk = ~clk;

  result_collector #(.DW(8), .HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .done(done),
    .pe_c00(stb[0]), .pe_c01(stb[1]), .pe_c10(stb[2]), .pe_c11(stb[3]),
    .sa2x2_c00(stb[4]), .sa2x2_c01(stb[5]), .sa2x2_c10(stb[6]), .sa2x2_c11(stb[7]),
    .sa3x3_c00(stb[8]), .sa3x3_c01(stb[9]), .sa3x3_c10(stb[10]), .sa3x3_c11(stb[11]),
    .pe_out(dat[0]), .sa2x2_out(dat[1]), .sa3x3_out(dat[2]),
    .display_output(d_out[0]), .display_idx(d_idx[0]), .display_valid(d_valid[0]),
    .busy(d_busy[0]), .all_captured(d_allc[0])
  );

  result_collector #(.DW(8), .HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .done(done),
    .pe_c00(stb[0]), .pe_c01(stb[1]), .pe_c10(stb[2]), .pe_c11(stb[3]),
    .sa2x2_c00(stb[4]), .sa2x2_c01(stb[5]), .sa2x2_c10(stb[6]), .sa2x2_c11(stb[7]),
    .sa3x3_c00(stb[8]), .sa3x3_c01(stb[9]), .sa3x3_c10(stb[10]), .sa3x3_c11(stb[11]),
    .pe_out(dat[0]), .sa2x2_out(dat[1]), .sa3x3_out(dat[2]),
    .display_output(d_out[1]), .display_idx(d_idx[1]), .display_valid(d_valid[1]),
    .busy(d_busy[1]), .all_captured(d_allc[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on each rising edge, then compare both builds just after it.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 12; i++) m_r[i] = 8'h00;
      m_cap = '0;
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = 0;
        m_t[k] = 0;
      end
    end else begin
      if (m_phase[0] == 0) begin
        for (int i = 0; i < 12; i++) begin
          if (stb[i]) begin
            m_r[i] = dat[i/4];
            m_cap[i] = 1'b1;
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (m_phase[k] == 0) begin
          if (done) begin
            m_phase[k] = 1;
            m_t[k] = 0;
          end
        end else if (m_phase[k] == 1) begin
          m_t[k]++;
          if (m_t[k] == 12 * hold[k]) m_phase[k] = 2;
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      int e_idx;
      int e_out;
      e_idx = (m_phase[k] == 1) ? m_t[k] / hold[k] : (m_phase[k] == 2) ? 11 : 0;
      e_out = (m_phase[k] == 0) ? 0 : int'(m_r[e_idx]);
      chk($sformatf("display_output[%0d]", k), int'(d_out[k]), e_out);
      chk($sformatf("display_idx[%0d]", k), int'(d_idx[k]), e_idx);
      chk($sformatf("display_valid[%0d]", k), int'(d_valid[k]), int'(m_phase[k] == 1));
      chk($sformatf("busy[%0d]", k), int'(d_busy[k]), int'(m_phase[k] == 1));
      chk($sformatf("all_captured[%0d]", k), int'(d_allc[k]), int'(m_cap == 12'hFFF));
    end
  end

  // Drive one cycle of inputs at a falling edge and wait for the next falling edge.
  task automatic cyc(input logic [11:0] s, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic d);
    stb = s;
    dat[0] = a;
    dat[1] = b;
    dat[2] = c;
    done = d;
    @(negedge clk);
  endtask

  // Asserted at a falling edge: outputs must clear without any clock edge.
  task automatic hard_reset();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_out[%0d]", k), int'(d_out[k]), 0);
      chk($sformatf("rst_idx[%0d]", k), int'(d_idx[k]), 0);
      chk($sformatf("rst_valid[%0d]", k), int'(d_valid[k]), 0);
      chk($sformatf("rst_busy[%0d]", k), int'(d_busy[k]), 0);
      chk($sformatf("rst_allc[%0d]", k), int'(d_allc[k]), 0);
    end
    stb = '0;
    done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(12'h000, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  initial begin
    int v4;
    int v1;
    hold[0] = 4;
    hold[1] = 1;
    dat[0] = '0;
    dat[1] = '0;
    dat[2] = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full sequence 0x10..0x1B, with a strobe pulse during SHOW that must be ignored.
    hard_reset();
    for (int i = 0; i < 12; i++)
      cyc(12'(1 << i), 8'(8'h10 + i), 8'(8'h10 + i), 8'(8'h10 + i), 1'b0);
    cyc(12'h000, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("seq_first_out", int'(d_out[0]), 8'h10);
    chk("seq_first_idx", int'(d_idx[0]), 0);
    chk("seq_allc", int'(d_allc[0]), 1);
    v4 = int'(d_valid[0]);
    v1 = int'(d_valid[1]);
    for (int n = 1; n <= 55; n++) begin
      cyc((n == 2) ? 12'h010 : 12'h000, 8'h00, 8'hFF, 8'h00, 1'b1);
      v4 += int'(d_valid[0]);
      v1 += int'(d_valid[1]);
      if (n == 16) chk("seq_slot4_kept", int'(d_out[0]), 8'h14);
      if (n == 47) chk("seq_last_out", int'(d_out[0]), 8'h1B);
    end
    chk("seq_valid_cycles_h4", v4, 48);
    chk("seq_valid_cycles_h1", v1, 12);
    chk("fin_out", int'(d_out[0]), 8'h1B);
    chk("fin_idx", int'(d_idx[0]), 11);
    chk("fin_valid", int'(d_valid[0]), 0);

    // Recapture: last value wins.
    hard_reset();
    cyc(12'h002, 8'h05, 8'h00, 8'h00, 1'b0);
    cyc(12'h000, 8'h00, 8'h00, 8'h00, 1'b0);
    cyc(12'h002, 8'h07, 8'h00, 8'h00, 1'b0);
    cyc(12'h000, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("recap_slot0", int'(d_out[0]), 0);
    chk("recap_allc", int'(d_allc[0]), 0);
    idle(4);
    chk("recap_slot1", int'(d_out[0]), 8'h07);
    idle(50);

    // Capture on the same edge that done first rises.
    hard_reset();
    cyc(12'h001, 8'h33, 8'h00, 8'h00, 1'b0);
    cyc(12'h800, 8'h00, 8'h00, 8'hAA, 1'b1);
    chk("same_edge_out", int'(d_out[0]), 8'h33);
    chk("same_edge_valid", int'(d_valid[0]), 1);
    idle(44);
    chk("same_edge_slot11", int'(d_out[0]), 8'hAA);
    idle(8);

    // Reset at slot 6 of SHOW, then a fresh run.
    hard_reset();
    for (int i = 0; i < 12; i++)
      cyc(12'(1 << i), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    cyc(12'h000, 8'h00, 8'h00, 8'h00, 1'b1);
    idle(24);
    chk("mid_show_idx", int'(d_idx[0]), 6);
    hard_reset();
    for (int i = 0; i < 12; i++)
      cyc(12'(1 << (11 - i)), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    cyc(12'h000, 8'h00, 8'h00, 8'h00, 1'b1);
    idle(52);

    // Randomised rounds: sparse strobes, random done timing, occasional early reset.
    for (int r = 0; r < 25; r++) begin
      int ncol;
      int nrun;
      hard_reset();
      ncol = int'($urandom_range(1, 30));
      for (int i = 0; i < ncol; i++)
        cyc(12'($urandom & $urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
      cyc(12'($urandom & $urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      nrun = int'($urandom_range(0, 56));
      for (int i = 0; i < nrun; i++)
        cyc(12'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
